// File: rtl/fir_tap_seq_pkg.sv
// fir_tap_seq_pkg: shared FSM state type and sizing helpers
// for the time-multiplexed FIR tap sequencer.
package fir_tap_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    function automatic int acc_width(int dw, int cw, int taps);
        return dw + cw + $clog2(taps);
    endfunction

    function automatic logic signed [127:0] max_s(int dw);
        return (128'sd1 <<< (dw - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] min_s(int dw);
        return -(128'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample/result handshakes plus the
// coefficient write port of the FIR tap sequencer.
interface fir_tap_sequencer_if #(
    parameter int DW   = 32,
    parameter int CW   = 16,
    parameter int TAPS = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DW-1:0]      in_data;
    logic                      coef_we;
    logic [$clog2(TAPS)-1:0]   coef_addr;
    logic signed [CW-1:0]      coef_wdata;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [DW-1:0]      out_data;

    modport master (
        output in_valid, in_data,
        output coef_we, coef_addr, coef_wdata,
        output out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data,
        input  coef_we, coef_addr, coef_wdata,
        input  out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac.sv
// fir_mac: registered full-precision signed multiply-accumulate
// with synchronous clear (priority) and enable.
module fir_mac #(
    parameter int DW   = 32,
    parameter int CW   = 16,
    parameter int ACCW = 51
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [CW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);
    localparam int PW = DW + CW;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: one shared MAC walks all taps per sample.
// Define FIR_TAP_SEQ_ROUND_EN for round-half-up before the shift.
module fir_tap_sequencer
    import fir_tap_seq_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CW    = 16,
    parameter int TAPS  = 8,
    parameter int SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    fir_tap_sequencer_if.slave bus,
    output logic               busy
);
    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = acc_width(DW, CW, TAPS);
    localparam logic signed [127:0] MAX_W = max_s(DW);
    localparam logic signed [127:0] MIN_W = min_s(DW);
    localparam logic signed [ACCW:0] MAX_V = MAX_W[ACCW:0];
    localparam logic signed [ACCW:0] MIN_V = MIN_W[ACCW:0];

    state_t                 state, state_nx;
    logic [AW-1:0]          wr_ptr, k, rd_idx;
    logic signed [DW-1:0]   dly  [TAPS];
    logic signed [CW-1:0]   coef [TAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW:0]   ext, shf;
    logic signed [DW-1:0]   sat, out_q;
    logic                   accept, coef_ok, out_vld;

    assign accept        = bus.in_valid && (state == IDLE);
    assign coef_ok       = bus.coef_we && (state == IDLE);
    assign rd_idx        = wr_ptr - k;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_q;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (k == AW'(TAPS - 1)) state_nx = OUT;
            OUT:     if (out_vld && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            k      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                k      <= '0;
            end else if (state == MAC) begin
                k <= k + AW'(1);
            end
        end
    end

    // wr_ptr always names the newest sample once the write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                dly[i]  <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (accept) dly[wr_ptr + AW'(1)] <= bus.in_data;
            if (coef_ok) coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    fir_mac #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == MAC),
        .a     (dly[rd_idx]),
        .b     (coef[k]),
        .acc   (acc)
    );

    assign ext = {acc[ACCW-1], acc};

`ifdef FIR_TAP_SEQ_ROUND_EN
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACCW:0] ONE = 1;
    localparam logic signed [ACCW:0] RND = (SHIFT > 0) ? (ONE <<< RS) : '0;
    assign shf = (ext + RND) >>> SHIFT;
`else
    assign shf = ext >>> SHIFT;
`endif

    always_comb begin
        if (shf > MAX_V) begin
            sat = MAX_V[DW-1:0];
        end else if (shf < MIN_V) begin
            sat = MIN_V[DW-1:0];
        end else begin
            sat = shf[DW-1:0];
        end
    end

    // first OUT cycle captures the settled accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (state == OUT && !out_vld) begin
            out_q   <= sat;
            out_vld <= 1'b1;
        end else if (out_vld && bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed vectors against a SHIFT=0 and a
// SHIFT=2 sequencer driven in lockstep.
module tb_fir_tap_sequencer;
    localparam int TAPS = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, busy2;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.DW(32), .CW(16), .TAPS(TAPS)) a_if ();
    fir_tap_sequencer_if #(.DW(32), .CW(16), .TAPS(TAPS)) b_if ();

    assign b_if.in_valid   = a_if.in_valid;
    assign b_if.in_data    = a_if.in_data;
    assign b_if.coef_we    = a_if.coef_we;
    assign b_if.coef_addr  = a_if.coef_addr;
    assign b_if.coef_wdata = a_if.coef_wdata;
    assign b_if.out_ready  = a_if.out_ready;

    fir_tap_sequencer #(
        .DW(32), .CW(16), .TAPS(TAPS), .SHIFT(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .busy(busy)
    );

    fir_tap_sequencer #(
        .DW(32), .CW(16), .TAPS(TAPS), .SHIFT(2)
    ) u_shf (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_coef(input int a, input int v);
        @(negedge clk);
        a_if.coef_we    = 1'b1;
        a_if.coef_addr  = 3'(a);
        a_if.coef_wdata = 16'(v);
        @(negedge clk);
        a_if.coef_we = 1'b0;
    endtask

    // wr: 0 none, 1 coef[0]=99 during MAC, 2 coef[0]=3 with the accept
    task automatic send(input int d, input int hold, input int wr,
                        output logic [31:0] res, output logic [31:0] res2,
                        output int lat);
        int t;
        logic [31:0] held;
        t = 0;
        @(negedge clk);
        while (!a_if.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        if (wr == 2) begin
            a_if.coef_we = 1'b1; a_if.coef_addr = 3'd0; a_if.coef_wdata = 16'd3;
        end
        @(negedge clk);
        a_if.in_valid = 1'b0;
        a_if.coef_we  = 1'b0;
        if (wr == 1) begin
            a_if.coef_we = 1'b1; a_if.coef_addr = 3'd0; a_if.coef_wdata = 16'd99;
        end
        lat = 0;
        while (!a_if.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            a_if.coef_we = 1'b0;
        end
        res  = a_if.out_data;
        res2 = b_if.out_data;
        held = res;
        for (int i = 0; i < hold; i++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = 1000;
            @(negedge clk);
            check("bp_out_valid", 32'(a_if.out_valid), 32'd1);
            check("bp_out_data", a_if.out_data, held);
            check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
        end
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        a_if.out_ready = 1'b0;
        if (hold > 0) begin
            check("bp_release_valid", 32'(a_if.out_valid), 32'd0);
            check("bp_release_ready", 32'(a_if.in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] r, r2;
        int lat;
        logic seen;
        rst_n           = 1'b0;
        a_if.in_valid   = 1'b0;
        a_if.in_data    = '0;
        a_if.coef_we    = 1'b0;
        a_if.coef_addr  = '0;
        a_if.coef_wdata = '0;
        a_if.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(a_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_data", a_if.out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_busy_shf", 32'(busy2), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < TAPS; k++) set_coef(k, k + 1);
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? 1 : 0, 0, 0, r, r2, lat);
            check("impulse_out", r, 32'(n + 1));
            check("impulse_latency", 32'(lat), 32'(TAPS + 1));
        end

        do_reset();
        for (int k = 0; k < TAPS; k++) set_coef(k, 1);
        for (int n = 0; n < 10; n++) begin
            send(10, 0, 0, r, r2, lat);
            check("step_out", r, 32'(10 * ((n < 8) ? n + 1 : 8)));
        end

        send(5, 5, 0, r, r2, lat);
        check("bp_result", r, 32'd75);
        send(0, 0, 0, r, r2, lat);
        check("bp_no_accept", r, 32'd65);

        do_reset();
        for (int k = 0; k < TAPS; k++) set_coef(k, 32767);
        for (int n = 0; n < TAPS; n++) begin
            send(32'h7fffffff, 0, 0, r, r2, lat);
            check("sat_pos", r, 32'h7fffffff);
        end
        for (int n = 1; n <= TAPS; n++) begin
            send(32'h80000000, 0, 0, r, r2, lat);
            if (n == 4) check("sat_mixed", r, 32'hfffe0004);
            if (n == 8) check("sat_neg", r, 32'h80000000);
        end

        do_reset();
        set_coef(0, 1);
        send(7, 0, 1, r, r2, lat);
        check("guard_cur", r, 32'd7);
        send(5, 0, 0, r, r2, lat);
        check("guard_dropped", r, 32'd5);
        set_coef(0, 99);
        send(2, 0, 0, r, r2, lat);
        check("guard_idle_write", r, 32'd198);
        send(4, 0, 2, r, r2, lat);
        check("write_with_accept", r, 32'd12);

        do_reset();
        set_coef(0, 1);
        send(3, 0, 0, r, r2, lat);
        check("shift0_pos", r, 32'd3);
`ifdef FIR_TAP_SEQ_ROUND_EN
        check("shift2_pos", r2, 32'd1);
`else
        check("shift2_pos", r2, 32'd0);
`endif
        send(-6, 0, 0, r, r2, lat);
        check("shift0_neg", r, 32'hfffffffa);
`ifdef FIR_TAP_SEQ_ROUND_EN
        check("shift2_neg", r2, 32'hffffffff);
`else
        check("shift2_neg", r2, 32'hfffffffe);
`endif

        @(negedge clk);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 5;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mac_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (TAPS + 4) begin
            @(negedge clk);
            if (a_if.out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_in_ready", 32'(a_if.in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
